// File: rtl/plab3_mem_line_responder.sv
// plab3_mem_line_responder: single-outstanding line memory with fixed response latency
// Ports: clk; reset (sync, active-low); memreq_msg/val/rdy line request {type,opaque,addr,len,data};
//        memresp_msg/val/rdy response {type,opaque,len=0,data}.
// Optional macro PLAB3_MEM_LINE_RESPONDER_INIT_EN adds an INIT sweep zeroing every line after reset.
module plab3_mem_line_responder #(
  parameter int nlines  = 64,
  parameter int latency = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [173:0] memreq_msg,
  input  logic         memreq_val,
  output logic         memreq_rdy,
  output logic [141:0] memresp_msg,
  output logic         memresp_val,
  input  logic         memresp_rdy
);
  localparam int iw = $clog2(nlines);
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
    , INIT
`endif
  } state_t;
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
  localparam state_t reset_state = INIT;
  logic [iw-1:0] init_q, init_d;
`else
  localparam state_t reset_state = IDLE;
`endif
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] type_q, type_d;
  logic [7:0] opaque_q, opaque_d;
  logic [127:0] data_q, data_d;
  logic [127:0] mem_q [nlines];
  logic mem_we;
  logic [iw-1:0] mem_idx;
  logic [127:0] mem_wdata, mask;
  logic [1:0] req_type;
  logic [7:0] req_opaque;
  logic [31:0] req_addr;
  logic [3:0] req_len;
  logic [127:0] req_data;
  logic [iw-1:0] req_idx;
  logic unused_addr;
  assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;
  assign req_idx = req_addr[4 +: iw];
  assign unused_addr = ^req_addr[31:4+iw];
  // byte lanes written: all for len 0, else offset..offset+len-1 clipped at byte 15
  always_comb begin
    mask = '0;
    for (int i = 0; i < 16; i++)
      mask[i*8 +: 8] = (req_len == 4'd0 || (i >= int'(req_addr[3:0]) && i < int'(req_addr[3:0]) + int'(req_len))) ? 8'hff : 8'h00;
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    type_d = type_q;
    opaque_d = opaque_q;
    data_d = data_q;
    mem_we = 1'b0;
    mem_idx = req_idx;
    mem_wdata = (mem_q[req_idx] & ~mask) | (req_data & mask);
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
    init_d = init_q;
`endif
    case (state_q)
      IDLE: if (memreq_val) begin
        type_d = req_type;
        opaque_d = req_opaque;
        data_d = req_type == 2'd1 ? '0 : mem_q[req_idx];
        mem_we = req_type == 2'd1;
        cnt_d = 4'(latency);
        state_d = latency == 0 ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? RESP : WAIT;
      end
      RESP: state_d = memresp_rdy ? IDLE : RESP;
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
      INIT: begin
        mem_we = 1'b1;
        mem_idx = init_q;
        mem_wdata = '0;
        init_d = init_q + iw'(1);
        state_d = init_q == iw'(nlines - 1) ? IDLE : INIT;
      end
`endif
      default: state_d = IDLE;
    endcase
    // reset wins over everything, including a same-cycle write
    if (!reset) begin
      state_d = reset_state;
      cnt_d = '0;
      type_d = '0;
      opaque_d = '0;
      data_d = '0;
      mem_we = 1'b0;
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
      init_d = '0;
`endif
    end
  end
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    type_q <= type_d;
    opaque_q <= opaque_d;
    data_q <= data_d;
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
    init_q <= init_d;
`endif
    if (mem_we) mem_q[mem_idx] <= mem_wdata;
  end
  assign memreq_rdy = reset && state_q == IDLE;
  assign memresp_val = reset && state_q == RESP;
  assign memresp_msg = {type_q, opaque_q, 4'd0, data_q};
endmodule

// File: tb/tb_plab3_mem_line_responder.sv
// tb_plab3_mem_line_responder: directed plus randomized checks against a line-array model
module tb_plab3_mem_line_responder;
  localparam int NL = 16;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic reset;
  logic [173:0] memreq_msg;
  logic memreq_val;
  logic memreq_rdy;
  logic [141:0] memresp_msg;
  logic memresp_val;
  logic memresp_rdy;
  int passed = 0;
  int total = 0;
  logic [127:0] model [NL];
  plab3_mem_line_responder #(.nlines(NL), .latency(LAT)) dut (
    .clk(clk), .reset(reset), .memreq_msg(memreq_msg), .memreq_val(memreq_val),
    .memreq_rdy(memreq_rdy), .memresp_msg(memresp_msg), .memresp_val(memresp_val),
    .memresp_rdy(memresp_rdy)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "timeout");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [141:0] obs, input logic [141:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic do_req(input logic [1:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [3:0] ln, input logic [127:0] d, input int hold);
    logic [127:0] exp_d;
    logic [141:0] exp_m;
    int n;
    n = 0;
    while (memreq_rdy !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("req_rdy_idle", memreq_rdy, 1);
    if (t == 2'd1) begin
      for (int b = 0; b < 16; b++)
        if (ln == 0 || (b >= int'(a[3:0]) && b < int'(a[3:0]) + int'(ln)))
          model[a[7:4]][b*8 +: 8] = d[b*8 +: 8];
      exp_d = '0;
    end else exp_d = model[a[7:4]];
    exp_m = {t, op, 4'd0, exp_d};
    memreq_msg = {t, op, a, ln, d};
    memreq_val = 1'b1;
    tick();
    memreq_val = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk("wait_val", memresp_val, 0);
      chk("wait_rdy", memreq_rdy, 0);
      tick();
    end
    chk("resp_val", memresp_val, 1);
    chk("resp_msg", memresp_msg, exp_m);
    chk("resp_rdy", memreq_rdy, 0);
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_val", memresp_val, 1);
      chk("hold_msg", memresp_msg, exp_m);
      chk("hold_rdy", memreq_rdy, 0);
    end
    memresp_rdy = 1'b1;
    tick();
    memresp_rdy = 1'b0;
    chk("done_val", memresp_val, 0);
    chk("done_rdy", memreq_rdy, 1);
  endtask
  task automatic after_reset;
    reset = 1'b1;
    #1;
`ifdef PLAB3_MEM_LINE_RESPONDER_INIT_EN
    for (int i = 0; i < NL; i++) model[i] = '0;
    for (int c = 0; c < NL; c++) begin
      chk("init_rdy", memreq_rdy, 0);
      tick();
    end
`endif
    chk("post_reset_rdy", memreq_rdy, 1);
  endtask
  initial begin
    logic [127:0] d;
    reset = 1'b0;
    memreq_val = 1'b0;
    memresp_rdy = 1'b0;
    memreq_msg = '0;
    repeat (3) tick();
    chk("rst_rdy", memreq_rdy, 0);
    chk("rst_val", memresp_val, 0);
    chk("rst_msg", memresp_msg, 0);
    after_reset();
    for (int i = 0; i < NL; i++)
      do_req(2'd1, 8'(i), {$urandom} & 32'hffff_fff0 | 32'(i << 4), 4'd0,
             {$urandom, $urandom, $urandom, $urandom}, 0);
    do_req(2'd1, 8'h11, 32'h40, 4'd0, 128'h0123456789abcdef0123456789abcdef, 0);
    do_req(2'd0, 8'h22, 32'h40, 4'd0, '0, 0);
    do_req(2'd1, 8'h33, 32'h40, 4'd0, '0, 5);
    d = 128'hddccbbaa_99887766_55443322_11ffeedd;
    do_req(2'd1, 8'h44, 32'h4e, 4'd4, d, 0);
    do_req(2'd0, 8'h55, 32'hfff0_004e, 4'd0, '0, 0);
    chk("partial_line", model[4], {d[127:112], 112'd0});
    do_req(2'd2, 8'h66, 32'h40, 4'd0, '1, 1);
    do_req(2'd3, 8'h77, 32'h44, 4'd0, '1, 0);
    do_req(2'd0, 8'h78, 32'h40, 4'd0, '0, 0);
    memreq_msg = {2'd0, 8'h99, 32'h50, 4'd0, 128'd0};
    memreq_val = 1'b1;
    tick();
    memreq_val = 1'b0;
    reset = 1'b0;
    #1;
    chk("wait_rst_val", memresp_val, 0);
    tick();
    chk("wait_rst_val2", memresp_val, 0);
    chk("wait_rst_rdy", memreq_rdy, 0);
    chk("wait_rst_msg", memresp_msg, 0);
    after_reset();
    for (int c = 0; c < LAT + 2; c++) begin
      tick();
      chk("no_stale_resp", memresp_val, 0);
    end
    do_req(2'd0, 8'haa, 32'h50, 4'd0, '0, 0);
    for (int r = 0; r < 60; r++)
      do_req(2'($urandom_range(0, 3)), 8'($urandom), $urandom, 4'($urandom_range(0, 15)),
             {$urandom, $urandom, $urandom, $urandom}, int'($urandom_range(0, 2)));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
